// File: rtl/motion_pkg.sv
// Shared types for the frame-difference motion sequencer: FSM encoding,
// coordinate width and the bounding-box record.
package motion_pkg;

  localparam int COORD_W = 10;
  localparam int CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_QUIET  = 2'd2,
    ST_ALARM  = 2'd3
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x_min;
    logic [COORD_W-1:0] x_max;
    logic [COORD_W-1:0] y_min;
    logic [COORD_W-1:0] y_max;
  } box_t;

  localparam int BOX_W = $bits(box_t);

endpackage

// File: rtl/motion_frame_ctrl_box_qualify.sv
// Combinational box validity check and candidate-box datapath.
// Optional feature: MOTION_BOX_SMOOTH_EN averages consecutive valid boxes.
module box_qualify
  import motion_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int MIN_W      = 4,
  parameter int MIN_H      = 4
) (
  input  logic [BOX_W-1:0] box_new,
  input  logic [BOX_W-1:0] box_old,
  input  logic             old_valid,
  output logic             valid,
  output logic [BOX_W-1:0] box_next
);

`ifdef MOTION_BOX_SMOOTH_EN
  localparam bit SMOOTH = 1'b1;
`else
  localparam bit SMOOTH = 1'b0;
`endif

  box_t bn;
  box_t bo;
  box_t avg_box;
  logic empty;

  function automatic logic span_ok(input logic [COORD_W-1:0] lo,
                                   input logic [COORD_W-1:0] hi,
                                   input int min_len);
    logic [COORD_W:0] len;
    len = {1'b0, hi} - {1'b0, lo} + (COORD_W+1)'(1);
    return (lo <= hi) && (len >= (COORD_W+1)'(min_len));
  endfunction

  function automatic logic [COORD_W-1:0] avg(input logic [COORD_W-1:0] a,
                                             input logic [COORD_W-1:0] b);
    logic [COORD_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[COORD_W:1];
  endfunction

  assign bn = box_new;
  assign bo = box_old;

  // A box anchored at the sentinel column/line lies outside the image.
  assign empty = (bn.x_min == COORD_W'(IMG_WIDTH)) || (bn.y_min == COORD_W'(IMG_HEIGHT));

  assign valid = !empty && span_ok(bn.x_min, bn.x_max, MIN_W)
                        && span_ok(bn.y_min, bn.y_max, MIN_H);

  always_comb begin
    avg_box.x_min = avg(bo.x_min, bn.x_min);
    avg_box.x_max = avg(bo.x_max, bn.x_max);
    avg_box.y_min = avg(bo.y_min, bn.y_min);
    avg_box.y_max = avg(bo.y_max, bn.y_max);
  end

  assign box_next = (SMOOTH && old_valid) ? avg_box : bn;

endmodule

// File: rtl/motion_frame_ctrl.sv
// Per-frame warm-up/quiet/alarm sequencer: samples the box at each vsync
// falling edge, schedules background writes, publishes a latched box.
// Optional feature: MOTION_BOX_SMOOTH_EN (handled in box_qualify).
module motion_frame_ctrl
  import motion_pkg::*;
#(
  parameter int IMG_WIDTH        = 640,
  parameter int IMG_HEIGHT       = 480,
  parameter int WARMUP_FRAMES    = 4,
  parameter int ON_FRAMES        = 2,
  parameter int OFF_FRAMES       = 8,
  parameter int MIN_W            = 4,
  parameter int MIN_H            = 4,
  parameter int BG_UPDATE_PERIOD = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        vsync_i,
  input  logic [9:0]  box_x_min_i,
  input  logic [9:0]  box_x_max_i,
  input  logic [9:0]  box_y_min_i,
  input  logic [9:0]  box_y_max_i,
  output logic        bg_wr_en,
  output logic        motion_alarm,
  output logic        box_valid,
  output logic [9:0]  box_x_min_o,
  output logic [9:0]  box_x_max_o,
  output logic [9:0]  box_y_min_o,
  output logic [9:0]  box_y_max_o,
  output logic [15:0] frame_cnt,
  output logic [1:0]  state_o
);

  state_t           state, state_nxt;
  logic             vsync_d1;
  logic             fe;
  logic [CNT_W-1:0] warm_cnt, warm_nxt;
  logic [CNT_W-1:0] on_cnt, on_nxt;
  logic [CNT_W-1:0] off_cnt, off_nxt;
  logic [CNT_W-1:0] bg_cnt, bg_cnt_nxt;
  logic [15:0]      frame_nxt;
  logic             bg_wr_nxt;
  logic             box_valid_nxt;
  box_t             box_q, box_nxt, box_in;
  logic             cand_valid;
  logic [BOX_W-1:0] cand_box;

  assign fe     = vsync_d1 && !vsync_i;
  assign box_in = {box_x_min_i, box_x_max_i, box_y_min_i, box_y_max_i};

  box_qualify #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .MIN_W     (MIN_W),
    .MIN_H     (MIN_H)
  ) u_qualify (
    .box_new  (box_in),
    .box_old  (box_q),
    .old_valid(box_valid),
    .valid    (cand_valid),
    .box_next (cand_box)
  );

  always_comb begin
    state_nxt     = state;
    warm_nxt      = warm_cnt;
    on_nxt        = on_cnt;
    off_nxt       = off_cnt;
    bg_cnt_nxt    = bg_cnt;
    frame_nxt     = frame_cnt;
    bg_wr_nxt     = bg_wr_en;
    box_valid_nxt = box_valid;
    box_nxt       = box_q;

    // Box publication happens on every frame event once past warm-up.
    if (fe && (state == ST_QUIET || state == ST_ALARM)) begin
      box_valid_nxt = cand_valid;
      if (cand_valid) box_nxt = cand_box;
    end

    if (fe && state != ST_IDLE) frame_nxt = frame_cnt + 16'd1;

    case (state)
      ST_IDLE: state_nxt = ST_WARMUP;
      ST_WARMUP: if (fe) begin
        bg_wr_nxt = 1'b1;
        warm_nxt  = warm_cnt + 1'b1;
        if (warm_cnt == CNT_W'(WARMUP_FRAMES - 1)) begin
          state_nxt = ST_QUIET;
          warm_nxt  = '0;
        end
      end
      ST_QUIET: if (fe) begin
        if (bg_cnt == CNT_W'(BG_UPDATE_PERIOD - 1)) begin
          bg_cnt_nxt = '0;
          bg_wr_nxt  = 1'b1;
        end else begin
          bg_cnt_nxt = bg_cnt + 1'b1;
          bg_wr_nxt  = 1'b0;
        end
        if (!cand_valid) begin
          on_nxt = '0;
        end else if (on_cnt == CNT_W'(ON_FRAMES - 1)) begin
          state_nxt = ST_ALARM;
          on_nxt    = '0;
          bg_wr_nxt = 1'b0;
        end else begin
          on_nxt = on_cnt + 1'b1;
        end
      end
      ST_ALARM: if (fe) begin
        if (cand_valid) begin
          off_nxt = '0;
        end else if (off_cnt == CNT_W'(OFF_FRAMES - 1)) begin
          state_nxt  = ST_QUIET;
          off_nxt    = '0;
          bg_cnt_nxt = '0;
        end else begin
          off_nxt = off_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Disable dominates any simultaneous frame event.
    if (!enable) begin
      state_nxt     = ST_IDLE;
      warm_nxt      = '0;
      on_nxt        = '0;
      off_nxt       = '0;
      bg_cnt_nxt    = '0;
      frame_nxt     = '0;
      bg_wr_nxt     = 1'b0;
      box_valid_nxt = 1'b0;
      box_nxt       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      vsync_d1  <= 1'b0;
      warm_cnt  <= '0;
      on_cnt    <= '0;
      off_cnt   <= '0;
      bg_cnt    <= '0;
      frame_cnt <= '0;
      bg_wr_en  <= 1'b0;
      box_valid <= 1'b0;
      box_q     <= '0;
    end else begin
      state     <= state_nxt;
      vsync_d1  <= vsync_i;
      warm_cnt  <= warm_nxt;
      on_cnt    <= on_nxt;
      off_cnt   <= off_nxt;
      bg_cnt    <= bg_cnt_nxt;
      frame_cnt <= frame_nxt;
      bg_wr_en  <= bg_wr_nxt;
      box_valid <= box_valid_nxt;
      box_q     <= box_nxt;
    end
  end

  assign motion_alarm = (state == ST_ALARM);
  assign state_o      = state;
  assign box_x_min_o  = box_q.x_min;
  assign box_x_max_o  = box_q.x_max;
  assign box_y_min_o  = box_q.y_min;
  assign box_y_max_o  = box_q.y_max;

endmodule

// File: tb/tb_motion_frame_ctrl.sv
// Directed bench for motion_frame_ctrl: frame-level reference model compared
// every cycle, plus hand-computed checkpoints along the scenario.
module tb_motion_frame_ctrl;

  localparam int WARMUP = 4;
  localparam int ONF    = 2;
  localparam int OFFF   = 8;
  localparam int PERIOD = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        vsync_i;
  logic [9:0]  bx0, bx1, by0, by1;
  logic        bg_wr_en, motion_alarm, box_valid;
  logic [9:0]  ox0, ox1, oy0, oy1;
  logic [15:0] frame_cnt;
  logic [1:0]  state_o;

  motion_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .vsync_i(vsync_i),
    .box_x_min_i(bx0), .box_x_max_i(bx1), .box_y_min_i(by0), .box_y_max_i(by1),
    .bg_wr_en(bg_wr_en), .motion_alarm(motion_alarm), .box_valid(box_valid),
    .box_x_min_o(ox0), .box_x_max_o(ox1), .box_y_min_o(oy0), .box_y_max_o(oy1),
    .frame_cnt(frame_cnt), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level reference model
  int m_state, m_bg, m_bv, m_fc, m_warm, m_on, m_off, m_bgc, m_d1;
  int m_box[4];

  function automatic bit box_ok(input int a, input int b, input int c, input int d);
    return (a <= b) && (b - a + 1 >= 4) && (c <= d) && (d - c + 1 >= 4);
  endfunction

  always @(posedge clk) begin
    int  nb[4];
    bit  fe, ok, smooth;
    int  prev;
    if (!rst_n) begin
      m_state = 0; m_bg = 0; m_bv = 0; m_fc = 0; m_warm = 0;
      m_on = 0; m_off = 0; m_bgc = 0; m_d1 = 0;
      for (int i = 0; i < 4; i++) m_box[i] = 0;
    end else begin
      fe = (m_d1 == 1) && !vsync_i;
      m_d1 = vsync_i ? 1 : 0;
      nb[0] = int'(bx0); nb[1] = int'(bx1); nb[2] = int'(by0); nb[3] = int'(by1);
      ok = box_ok(nb[0], nb[1], nb[2], nb[3]);
`ifdef MOTION_BOX_SMOOTH_EN
      smooth = 1;
`else
      smooth = 0;
`endif
      prev = m_state;
      if (!enable) begin
        m_state = 0; m_bg = 0; m_bv = 0; m_fc = 0; m_warm = 0;
        m_on = 0; m_off = 0; m_bgc = 0;
        for (int i = 0; i < 4; i++) m_box[i] = 0;
      end else if (prev == 0) begin
        m_state = 1;
      end else if (fe) begin
        m_fc = (m_fc + 1) % 65536;
        if (prev >= 2) begin
          if (ok) begin
            for (int i = 0; i < 4; i++)
              m_box[i] = (smooth && m_bv == 1) ? (m_box[i] + nb[i]) / 2 : nb[i];
            m_bv = 1;
          end else m_bv = 0;
        end
        if (prev == 1) begin
          m_bg = 1;
          m_warm++;
          if (m_warm == WARMUP) begin m_state = 2; m_warm = 0; end
        end else if (prev == 2) begin
          if (m_bgc == PERIOD - 1) begin m_bgc = 0; m_bg = 1; end
          else begin m_bgc++; m_bg = 0; end
          m_on = ok ? m_on + 1 : 0;
          if (m_on == ONF) begin m_state = 3; m_on = 0; m_bg = 0; end
        end else begin
          m_off = ok ? 0 : m_off + 1;
          if (m_off == OFFF) begin m_state = 2; m_off = 0; m_bgc = 0; end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] act, exp;
    if (chk_en) begin
      act = {3'b0, state_o, motion_alarm, bg_wr_en, box_valid, ox0, ox1, oy0, oy1, frame_cnt};
      exp = {3'b0, 2'(m_state), (m_state == 3), 1'(m_bg), 1'(m_bv),
             10'(m_box[0]), 10'(m_box[1]), 10'(m_box[2]), 10'(m_box[3]), 16'(m_fc)};
      check("cycle_model", act, exp);
    end
  end

  task automatic frame(input int a, input int b, input int c, input int d);
    @(negedge clk);
    bx0 = 10'(a); bx1 = 10'(b); by0 = 10'(c); by1 = 10'(d);
    vsync_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vsync_i = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bg_frames;
    rst_n = 1'b0; enable = 1'b0; vsync_i = 1'b0;
    bx0 = '0; bx1 = '0; by0 = '0; by1 = '0;
    @(posedge clk);
    chk_en = 1;
    repeat (2) @(negedge clk);
    check("reset_state", state_o, 0);
    check("reset_outputs", {bg_wr_en, motion_alarm, box_valid, frame_cnt}, 0);

    rst_n = 1'b1; enable = 1'b1;
    repeat (2) @(negedge clk);
    check("enter_warmup", state_o, 1);

    // Warm-up: four forced background loads
    frame(640, 0, 480, 0);
    check("warm_bg_wr", bg_wr_en, 1);
    check("warm_state", state_o, 1);
    for (int i = 0; i < 3; i++) frame(640, 0, 480, 0);
    check("warm_done_state", state_o, 2);
    check("warm_frame_cnt", frame_cnt, 4);
    check("warm_box_valid", box_valid, 0);

    // Two valid frames raise the alarm
    frame(100, 140, 50, 90);
    check("on1_alarm", motion_alarm, 0);
    check("on1_box_valid", box_valid, 1);
    frame(100, 140, 50, 90);
    check("on2_alarm", motion_alarm, 1);
    check("on2_box", {ox0, ox1, oy0, oy1}, {10'd100, 10'd140, 10'd50, 10'd90});
    check("on2_bg_wr", bg_wr_en, 0);

    // Empty sentinel for eight frames drops the alarm
    frame(640, 0, 480, 0);
    check("off1_box_valid", box_valid, 0);
    check("off1_box_held", ox0, 100);
    for (int i = 0; i < 6; i++) frame(640, 0, 480, 0);
    check("off7_state", state_o, 3);
    frame(640, 0, 480, 0);
    check("off8_state", state_o, 2);
    check("off8_frame_cnt", frame_cnt, 14);

    // Narrow box never qualifies; one background refresh in sixteen frames
    bg_frames = 0;
    for (int i = 0; i < 16; i++) begin
      frame(100, 102, 50, 59);
      if (bg_wr_en) bg_frames++;
    end
    check("narrow_bg_frames", bg_frames, 1);
    check("narrow_alarm", motion_alarm, 0);
    check("narrow_box_valid", box_valid, 0);

    // Two distinct valid boxes: second is averaged when smoothing is built in
    frame(100, 140, 50, 90);
    check("s1_box", {ox0, ox1, oy0, oy1}, {10'd100, 10'd140, 10'd50, 10'd90});
    frame(110, 150, 60, 100);
`ifdef MOTION_BOX_SMOOTH_EN
    check("s2_box", {ox0, ox1, oy0, oy1}, {10'd105, 10'd145, 10'd55, 10'd95});
`else
    check("s2_box", {ox0, ox1, oy0, oy1}, {10'd110, 10'd150, 10'd60, 10'd100});
`endif
    check("s2_state", state_o, 3);

    // Drop enable on the very cycle of a frame event while in alarm
    @(negedge clk); vsync_i = 1'b1;
    @(negedge clk);
    @(negedge clk); vsync_i = 1'b0; enable = 1'b0;
    @(negedge clk);
    check("dis_state", state_o, 0);
    check("dis_outputs", {bg_wr_en, motion_alarm, box_valid, ox0, ox1, oy0, oy1, frame_cnt}, 0);

    // Reset pulsed while vsync is high must not produce a frame event
    enable = 1'b1;
    @(negedge clk); vsync_i = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1; vsync_i = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_frame_cnt", frame_cnt, 0);
    check("rst_mid_state", state_o, 1);
    check("rst_mid_bg_wr", bg_wr_en, 0);
    frame(640, 0, 480, 0);
    check("post_rst_frame_cnt", frame_cnt, 1);
    check("post_rst_bg_wr", bg_wr_en, 1);

    repeat (3) @(negedge clk);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
